// File: rtl/cic_i_if.sv
// cic_i_if: strobed sample-stream bundle between upstream DSP, cic_i and the DAC/upconverter side
interface cic_i_if #(
    parameter int INP_DW = 17,
    parameter int OUT_DW = 14
);
    logic signed [INP_DW-1:0] inp_samp_data;
    logic                     inp_samp_str;
    logic signed [OUT_DW-1:0] out_samp_data;
    logic                     out_samp_str;
    logic                     overrun;

    modport master (
        output inp_samp_data, inp_samp_str,
        input  out_samp_data, out_samp_str, overrun
    );

    modport slave (
        input  inp_samp_data, inp_samp_str,
        output out_samp_data, out_samp_str, overrun
    );
endinterface

// File: rtl/cic_i.sv
// cic_i: CIC interpolator - CIC_N combs at the input rate, zero-stuffing by CIC_R, CIC_N integrators at the output rate.
// Optional macro CIC_I_ROUND_EN: half-up rounded, saturated output with one extra register stage
// (bypassed when OUT_DW == B_FULL). Without it the output is truncated.
module cic_i #(
    parameter int INP_DW   = 17,
    parameter int OUT_DW   = 14,
    parameter int CIC_R    = 100,
    parameter int CIC_N    = 7,
    parameter int CIC_M    = 1,
    parameter int OUT_STEP = 1
) (
    input logic    clk,
    input logic    reset_n,
    input logic    clear,
    cic_i_if.slave s
);
    // ceil(log2(v)) for gains far wider than 32 bits
    function automatic int clog2_l(input logic [255:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 256; i++)
            if ((256'd1 << i) < v) r = i + 1;
        return r;
    endfunction

    // (R*M)**N / R computed exactly as M**N * R**(N-1)
    function automatic logic [255:0] gain_f();
        logic [255:0] g;
        g = 256'd1;
        for (int i = 0; i < CIC_N; i++)
            g = g * 256'(CIC_M) * 256'(i == 0 ? 1 : CIC_R);
        return g;
    endfunction

    localparam int B_FULL = INP_DW + clog2_l(gain_f());
    localparam int SW     = $clog2(CIC_R);
    localparam int TW     = OUT_STEP > 1 ? $clog2(OUT_STEP) : 1;
`ifdef CIC_I_ROUND_EN
    localparam bit RND = OUT_DW < B_FULL;
`else
    localparam bit RND = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [SW-1:0]            slot_cnt;
    logic [TW-1:0]            step_cnt;
    logic [CIC_N:0]           vld;
    logic signed [B_FULL-1:0] x_in;
    logic signed [B_FULL-1:0] cin    [CIC_N];
    logic signed [B_FULL-1:0] cmb    [CIC_N];
    logic signed [B_FULL-1:0] dly    [CIC_N][CIC_M];
    logic signed [B_FULL-1:0] itg    [CIC_N];
    logic signed [B_FULL-1:0] itg_nx [CIC_N];
    logic signed [OUT_DW-1:0] dat;
    logic                     str;
    logic                     ovr;
    logic                     busy;
    logic                     drop;
    logic                     slot;

    // a new sample landing on a busy pipeline/burst kills the slot of that edge and ends the burst
    assign busy = state == RUN || |vld;
    assign drop = s.inp_samp_str && busy;
    assign slot = !drop && (vld[CIC_N] || (state == RUN && step_cnt == TW'(OUT_STEP - 1)));

    assign s.out_samp_data = dat;
    assign s.out_samp_str  = str;
    assign s.overrun       = ovr;

    // comb stage inputs: sign-extended sample for stage 0, previous comb output after that
    always_comb begin
        cin[0] = x_in;
        for (int i = 1; i < CIC_N; i++) cin[i] = cmb[i-1];
    end

    // integrator next values: stage 0 takes the comb output on slot 0 and zeros otherwise
    always_comb begin
        itg_nx[0] = itg[0] + (vld[CIC_N] ? cmb[CIC_N-1] : '0);
        for (int i = 1; i < CIC_N; i++) itg_nx[i] = itg[i] + itg[i-1];
    end

    // input register and comb pipeline, each stage advancing only when its valid bit arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld  <= '0;
            x_in <= '0;
            for (int i = 0; i < CIC_N; i++) begin
                cmb[i] <= '0;
                for (int m = 0; m < CIC_M; m++) dly[i][m] <= '0;
            end
        end else if (clear) begin
            vld  <= '0;
            x_in <= '0;
            for (int i = 0; i < CIC_N; i++) begin
                cmb[i] <= '0;
                for (int m = 0; m < CIC_M; m++) dly[i][m] <= '0;
            end
        end else begin
            vld <= {vld[CIC_N-1:0], s.inp_samp_str};
            if (s.inp_samp_str) x_in <= B_FULL'(s.inp_samp_data);
            for (int i = 0; i < CIC_N; i++)
                if (vld[i]) begin
                    cmb[i]    <= cin[i] - dly[i][CIC_M-1];
                    dly[i][0] <= cin[i];
                    for (int m = 1; m < CIC_M; m++) dly[i][m] <= dly[i][m-1];
                end
        end
    end

    // burst FSM: slot 0 fires on comb completion, then R-1 more slots spaced OUT_STEP clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            slot_cnt <= '0;
            step_cnt <= '0;
            ovr      <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            slot_cnt <= '0;
            step_cnt <= '0;
            ovr      <= 1'b0;
        end else begin
            if (drop) ovr <= 1'b1;
            if (drop) begin
                state <= IDLE;
            end else if (vld[CIC_N]) begin
                state    <= RUN;
                slot_cnt <= SW'(1);
                step_cnt <= '0;
            end else if (state == RUN) begin
                if (step_cnt == TW'(OUT_STEP - 1)) begin
                    step_cnt <= '0;
                    slot_cnt <= slot_cnt + SW'(1);
                    if (slot_cnt == SW'(CIC_R - 1)) state <= IDLE;
                end else begin
                    step_cnt <= step_cnt + TW'(1);
                end
            end
        end
    end

    // integrators update once per slot and hold in between; wrap-around is intended
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CIC_N; i++) itg[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < CIC_N; i++) itg[i] <= '0;
        end else if (slot) begin
            itg <= itg_nx;
        end
    end

    if (RND) begin : g_rnd
        localparam int SH = B_FULL - OUT_DW - 1;
        logic signed [B_FULL-1:0] hold;
        logic                     hold_str;
        logic [B_FULL:0]          sum;

        assign sum = {hold[B_FULL-1], hold} + ((B_FULL + 1)'(1) << SH);

        // capture the new integrator value on the slot, round half-up and saturate one clock later
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hold     <= '0;
                hold_str <= 1'b0;
                dat      <= '0;
                str      <= 1'b0;
            end else if (clear) begin
                hold     <= '0;
                hold_str <= 1'b0;
                dat      <= '0;
                str      <= 1'b0;
            end else begin
                if (slot) hold <= itg_nx[CIC_N-1];
                hold_str <= slot;
                if (hold_str)
                    dat <= sum[B_FULL] != sum[B_FULL-1] ? {1'b0, {(OUT_DW-1){1'b1}}} : sum[B_FULL-1 -: OUT_DW];
                str <= hold_str;
            end
        end
    end else begin : g_trunc
        // register the truncated MSBs of the new last-integrator value on the slot edge
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dat <= '0;
                str <= 1'b0;
            end else if (clear) begin
                dat <= '0;
                str <= 1'b0;
            end else begin
                if (slot) dat <= itg_nx[CIC_N-1][B_FULL-1 -: OUT_DW];
                str <= slot;
            end
        end
    end
endmodule

// File: tb/tb_cic_i.sv
// tb_cic_i: table + scoreboard bench for cic_i at R=4, N=2, M=1, INP_DW=8, OUT_DW=10 (B_FULL=10).
// For this config every burst is 4x linear interpolation: y_j = j*x + (4-j)*x_prev.
module tb_cic_i;
    localparam int R = 4;
    localparam int N = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clear   = 1'b0;
    int   nvec    = 0;
    int   nerr    = 0;
    int   str_cnt = 0;
    bit   sb_on   = 1'b0;
    int   q [$];

    typedef struct {
        int x;
        int y [R];
    } vec_t;

    vec_t tbl [12];

    cic_i_if #(.INP_DW(8), .OUT_DW(10)) ifc ();

    cic_i #(
        .INP_DW(8), .OUT_DW(10), .CIC_R(R), .CIC_N(N), .CIC_M(1), .OUT_STEP(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clear(clear),
        .s(ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic signed [31:0] act, input int req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        ifc.inp_samp_data = 8'(x);
        ifc.inp_samp_str  = 1'b1;
        tick();
        ifc.inp_samp_str  = 1'b0;
    endtask

    // scoreboard: every output strobe pops one expected sample
    always @(negedge clk) begin
        if (ifc.out_samp_str) begin
            str_cnt++;
            if (sb_on) begin
                if (q.size() == 0) check("sb_spurious_strobe", ifc.out_samp_str, 0);
                else check("sb_data", ifc.out_samp_data, q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int prev;
        int b2b [5];
        tbl[0]  = '{1,    '{0, 1, 2, 3}};
        tbl[1]  = '{0,    '{4, 3, 2, 1}};
        tbl[2]  = '{0,    '{0, 0, 0, 0}};
        tbl[3]  = '{10,   '{0, 10, 20, 30}};
        tbl[4]  = '{10,   '{40, 40, 40, 40}};
        tbl[5]  = '{-128, '{40, -98, -236, -374}};
        tbl[6]  = '{-128, '{-512, -512, -512, -512}};
        tbl[7]  = '{127,  '{-512, -257, -2, 253}};
        tbl[8]  = '{127,  '{508, 508, 508, 508}};
        tbl[9]  = '{-5,   '{508, 376, 244, 112}};
        tbl[10] = '{0,    '{-20, -15, -10, -5}};
        tbl[11] = '{0,    '{0, 0, 0, 0}};
        b2b = '{20, 20, -20, 0, 0};
        ifc.inp_samp_data = '0;
        ifc.inp_samp_str  = 1'b0;
        repeat (3) tick();
        check("reset_data", ifc.out_samp_data, 0);
        check("reset_str", ifc.out_samp_str, 0);
        check("reset_overrun", ifc.overrun, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // table: inputs 16 clocks apart, first strobe N+2 clocks after the input strobe rises
        sb_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < R; j++) q.push_back(tbl[i].y[j]);
            send(tbl[i].x);
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!ifc.out_samp_str && lat < 10);
            check("latency", lat, N + 1);
            repeat (15 - lat) tick();
        end
        check("table_drain", q.size(), 0);

        // inputs spaced N+1+R clocks: every burst complete, no overrun
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < R; j++) q.push_back(j * b2b[i] + (R - j) * prev);
            prev = b2b[i];
            send(b2b[i]);
            repeat (N + R) tick();
        end
        repeat (10) tick();
        check("b2b_drain", q.size(), 0);
        check("b2b_no_overrun", ifc.overrun, 0);

        // clear after two strobes of a DC burst, then restart from zero state
        for (int j = 0; j < R; j++) q.push_back(10 * j);
        send(10);
        repeat (15) tick();
        q.push_back(40);
        q.push_back(40);
        base = str_cnt;
        send(10);
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_str", ifc.out_samp_str, 0);
        check("clear_data", ifc.out_samp_data, 0);
        repeat (10) tick();
        check("clear_strobes", str_cnt - base, 2);
        check("clear_drain", q.size(), 0);
        for (int j = 0; j < R; j++) q.push_back(10 * j);
        send(10);
        repeat (15) tick();
        for (int j = 0; j < R; j++) q.push_back(40);
        send(10);
        repeat (15) tick();
        check("post_clear_drain", q.size(), 0);

        // overrun: second input 6 clocks after the first drops the last slot of the first burst
        sb_on = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_clear", ifc.overrun, 0);
        base = str_cnt;
        send(10);
        repeat (5) tick();
        send(-10);
        check("ovr_first_burst", str_cnt - base, 3);
        check("ovr_flag", ifc.overrun, 1);
        repeat (2) tick();
        check("ovr_dropped_slot", str_cnt - base, 3);
        tick();
        check("ovr_new_burst_start", ifc.out_samp_str, 1);
        repeat (6) tick();
        check("ovr_second_burst", str_cnt - base, 7);
        check("ovr_sticky", ifc.overrun, 1);

        // asynchronous reset between clock edges in the middle of a burst
        send(10);
        repeat (4) tick();
        check("pre_reset_str", ifc.out_samp_str, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_data", ifc.out_samp_data, 0);
        check("async_reset_str", ifc.out_samp_str, 0);
        check("async_reset_overrun", ifc.overrun, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        base = str_cnt;
        repeat (10) tick();
        check("no_strobe_after_reset", str_cnt - base, 0);
        sb_on = 1'b1;
        for (int j = 0; j < R; j++) q.push_back(7 * j);
        send(7);
        repeat (15) tick();
        for (int j = 0; j < R; j++) q.push_back(28);
        send(7);
        repeat (15) tick();
        check("post_reset_drain", q.size(), 0);
        sb_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
